// File: rtl/rv_multicycle_sequencer.sv
// Multi-cycle control sequencer for an RV32I datapath: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, drives the datapath strobes and the shared
// memory port, traps on illegal opcodes or stalled memory, counts retirements.
module rv_multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       ir_opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             ldr_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Wait counter is 8 bits: the timeout limit never exceeds 255.
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic retire;
  logic req_c, we_c, ir_we_c, ldr_we_c, rf_we_c, pc_we_c, pc_src_c, trap_c;

  logic is_load, is_store, is_branch, is_legal;

  assign is_load   = (ir_opcode == OP_LOAD);
  assign is_store  = (ir_opcode == OP_STORE);
  assign is_branch = (ir_opcode == OP_BRANCH);
  assign is_legal  = (ir_opcode == OP_R)     || (ir_opcode == OP_I)     ||
                     (ir_opcode == OP_LUI)   || (ir_opcode == OP_AUIPC) ||
                     is_load || is_store || is_branch;

  // Next-state, wait/timeout tracking, retirement and raw strobe generation.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    wait_d       = '0;
    retire       = 1'b0;
    req_c        = 1'b0;
    we_c         = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we_c      = 1'b0;
    ldr_we_c     = 1'b0;
    rf_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    pc_src_c     = 1'b0;
    trap_c       = 1'b0;

    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_we_c  = 1'b1;
          pc_src_c = branch_taken;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        req_c        = 1'b1;
        mem_addr_sel = 1'b1;
        we_c         = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we_c = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            ldr_we_c = 1'b1;
            state_d  = S_WB;
          end
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  // State, wait counter, trap cause and retirement counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      cause_q   <= 2'b00;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are silenced the moment reset is asserted, not at the next edge.
  assign mem_req    = rst_n & req_c;
  assign mem_we     = rst_n & we_c;
  assign ir_we      = rst_n & ir_we_c;
  assign ldr_we     = rst_n & ldr_we_c;
  assign rf_we      = rst_n & rf_we_c;
  assign pc_we      = rst_n & pc_we_c;
  assign pc_src     = rst_n & pc_src_c;
  assign trap       = rst_n & trap_c;
  assign state      = state_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
// Bench for rv_multicycle_sequencer: a directed vector table, hand-written
// corner sequences and random instructions checked against an
// instruction-level model of the sequencing rules.
module tb_rv_multicycle_sequencer;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  // strobe vector order: {mem_req, mem_we, ir_we, ldr_we, rf_we, pc_we, pc_src, trap}
  localparam logic [7:0] SB_NONE  = 8'b0000_0000;
  localparam logic [7:0] SB_FWAIT = 8'b1000_0000;
  localparam logic [7:0] SB_FDONE = 8'b1010_0000;
  localparam logic [7:0] SB_WB    = 8'b0000_1100;
  localparam logic [7:0] SB_TRAP  = 8'b0000_0001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       ir_opcode;
  logic             branch_taken;
  logic             mem_ready;
  logic             mem_req, mem_we, mem_addr_sel, ir_we, ldr_we, rf_we, pc_we, pc_src;
  logic [2:0]       state;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  rv_multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .ldr_we(ldr_we), .rf_we(rf_we),
    .pc_we(pc_we), .pc_src(pc_src), .state(state), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n;
    logic [6:0]       opc;
    logic             taken;
    logic             ready;
    logic [2:0]       e_state;
    logic [7:0]       e_strb;
    logic             e_asel;
    logic [1:0]       e_cause;
    logic [CNT_W-1:0] e_instret;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // instruction-level model state
  logic [CNT_W-1:0] m_instret = '0;
  logic             m_trapped = 1'b0;
  logic [1:0]       m_cause   = 2'b00;

  function automatic vec_t mk(logic r, logic [6:0] o, logic t, logic rd, logic [2:0] s,
                              logic [7:0] sb, logic a, logic [CNT_W-1:0] ic);
    vec_t v;
    v.rst_n = r; v.opc = o; v.taken = t; v.ready = rd;
    v.e_state = s; v.e_strb = sb; v.e_asel = a; v.e_cause = 2'b00; v.e_instret = ic;
    return v;
  endfunction

  function automatic logic legal_op(logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUI};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    logic [7:0] got;
    logic       ok;
    @(negedge clk);
    rst_n        = v.rst_n;
    ir_opcode    = v.opc;
    branch_taken = v.taken;
    mem_ready    = v.ready;
    #1;
    n_vec++;
    got = {mem_req, mem_we, ir_we, ldr_we, rf_we, pc_we, pc_src, trap};
    ok  = (state === v.e_state) && (got === v.e_strb) && (trap_cause === v.e_cause) &&
          (instret === v.e_instret) && (!v.e_strb[7] || mem_addr_sel === v.e_asel);
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got state=%0d strb=%b asel=%b cause=%b instret=%0d, want state=%0d strb=%b asel=%b cause=%b instret=%0d",
               tag, state, got, mem_addr_sel, trap_cause, instret,
               v.e_state, v.e_strb, v.e_asel, v.e_cause, v.e_instret);
    end
  endtask

  // one model-predicted cycle
  task automatic mcyc(input logic r, input logic [6:0] o, input logic t, input logic rd,
                      input logic [2:0] s, input logic [7:0] sb, input logic a, input string tag);
    vec_t v;
    v = mk(r, o, t, rd, s, sb, a, m_instret);
    v.e_cause = m_cause;
    apply_vec(v, tag);
  endtask

  task automatic do_reset();
    mcyc(1'b0, 7'($urandom), rbit(), rbit(), m_trapped ? 3'd5 : 3'd0, SB_NONE, 1'b0, "reset");
    m_instret = '0;
    m_trapped = 1'b0;
    m_cause   = 2'b00;
  endtask

  task automatic trap_idle(input int n);
    for (int i = 0; i < n; i++)
      mcyc(1'b1, 7'($urandom), rbit(), rbit(), 3'd5, SB_TRAP, 1'b0, "trap_hold");
  endtask

  // Drive one instruction with fw fetch wait cycles and mw data wait cycles,
  // predicting every cycle from the instruction-level rules.
  task automatic run_instr(input logic [6:0] op, input logic taken, input int fw, input int mw);
    logic       rdy, ld, st;
    logic [7:0] sb;
    ld = (op == OP_LD);
    st = (op == OP_ST);
    begin : body
      for (int i = 0; i <= fw; i++) begin
        rdy = (i == fw);
        mcyc(1'b1, 7'($urandom), rbit(), rdy, 3'd0, rdy ? SB_FDONE : SB_FWAIT, 1'b0, "fetch");
        if (!rdy && i == MEM_TIMEOUT) begin
          m_trapped = 1'b1; m_cause = 2'b10; disable body;
        end
      end
      mcyc(1'b1, op, rbit(), rbit(), 3'd1, SB_NONE, 1'b0, "decode");
      if (!legal_op(op)) begin
        m_trapped = 1'b1; m_cause = 2'b01; disable body;
      end
      if (op == OP_BR) begin
        mcyc(1'b1, op, taken, rbit(), 3'd2, {5'b00000, 1'b1, taken, 1'b0}, 1'b0, "exec_branch");
        m_instret++;
        disable body;
      end
      mcyc(1'b1, op, rbit(), rbit(), 3'd2, SB_NONE, 1'b0, "exec");
      if (ld || st) begin
        for (int i = 0; i <= mw; i++) begin
          rdy = (i == mw);
          sb  = {1'b1, st, 1'b0, rdy & ld, 1'b0, rdy & st, 1'b0, 1'b0};
          mcyc(1'b1, op, rbit(), rdy, 3'd3, sb, 1'b1, "mem");
          if (!rdy && i == MEM_TIMEOUT) begin
            m_trapped = 1'b1; m_cause = 2'b10; disable body;
          end
        end
        if (st) begin
          m_instret++;
          disable body;
        end
      end
      mcyc(1'b1, op, rbit(), rbit(), 3'd4, SB_WB, 1'b0, "wb");
      m_instret++;
    end
    $display("instr op=%b taken=%0d fw=%0d mw=%0d -> instret=%0d trapped=%0d cause=%b",
             op, taken, fw, mw, m_instret, m_trapped, m_cause);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [7];
    logic [6:0] op;
    int         r, fw, mw;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUI};

    // directed table: reset, R-type, LOAD with 2 data waits, BRANCH taken/not, STORE
    tbl.push_back(mk(0, OP_R, 0, 1, 0, SB_NONE,  0, 0));
    tbl.push_back(mk(1, OP_R, 0, 1, 0, SB_FDONE, 0, 0));
    tbl.push_back(mk(1, OP_R, 1, 0, 1, SB_NONE,  0, 0));
    tbl.push_back(mk(1, OP_R, 1, 1, 2, SB_NONE,  0, 0));
    tbl.push_back(mk(1, OP_R, 0, 0, 4, SB_WB,    0, 0));
    tbl.push_back(mk(1, OP_LD, 0, 1, 0, SB_FDONE, 0, 1));
    tbl.push_back(mk(1, OP_LD, 0, 0, 1, SB_NONE,  0, 1));
    tbl.push_back(mk(1, OP_LD, 1, 0, 2, SB_NONE,  0, 1));
    tbl.push_back(mk(1, OP_LD, 0, 0, 3, 8'b1000_0000, 1, 1));
    tbl.push_back(mk(1, OP_LD, 0, 0, 3, 8'b1000_0000, 1, 1));
    tbl.push_back(mk(1, OP_LD, 0, 1, 3, 8'b1001_0000, 1, 1));
    tbl.push_back(mk(1, OP_LD, 0, 1, 4, SB_WB,    0, 1));
    tbl.push_back(mk(1, OP_BR, 0, 1, 0, SB_FDONE, 0, 2));
    tbl.push_back(mk(1, OP_BR, 0, 1, 1, SB_NONE,  0, 2));
    tbl.push_back(mk(1, OP_BR, 1, 1, 2, 8'b0000_0110, 0, 2));
    tbl.push_back(mk(1, OP_BR, 0, 1, 0, SB_FDONE, 0, 3));
    tbl.push_back(mk(1, OP_BR, 1, 1, 1, SB_NONE,  0, 3));
    tbl.push_back(mk(1, OP_BR, 0, 1, 2, 8'b0000_0100, 0, 3));
    tbl.push_back(mk(1, OP_ST, 0, 1, 0, SB_FDONE, 0, 4));
    tbl.push_back(mk(1, OP_ST, 0, 1, 1, SB_NONE,  0, 4));
    tbl.push_back(mk(1, OP_ST, 0, 1, 2, SB_NONE,  0, 4));
    tbl.push_back(mk(1, OP_ST, 0, 1, 3, 8'b1100_0100, 1, 4));

    rst_n = 1'b0; ir_opcode = '0; branch_taken = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) apply_vec(tbl[i], $sformatf("table[%0d]", i));
    m_instret = CNT_W'(5);
    do_reset();

    // fetch wait exactly at the limit, then one past it
    run_instr(OP_I, 1'b0, MEM_TIMEOUT, 0);
    run_instr(OP_R, 1'b0, MEM_TIMEOUT + 1, 0);
    trap_idle(5);
    do_reset();

    // illegal opcode holds TRAP with strobes quiet
    run_instr(7'b1111111, 1'b0, 0, 0);
    trap_idle(20);
    do_reset();

    // data-phase limit: store completes at the limit, load times out past it
    run_instr(OP_ST, 1'b0, 0, MEM_TIMEOUT);
    run_instr(OP_LD, 1'b0, 1, MEM_TIMEOUT + 1);
    trap_idle(3);
    do_reset();

    // reset pulse in the middle of a store's data phase
    run_instr(OP_R, 1'b0, 0, 0);
    mcyc(1'b1, OP_ST, 1'b0, 1'b1, 3'd0, SB_FDONE, 1'b0, "st_fetch");
    mcyc(1'b1, OP_ST, 1'b0, 1'b0, 3'd1, SB_NONE, 1'b0, "st_decode");
    mcyc(1'b1, OP_ST, 1'b0, 1'b0, 3'd2, SB_NONE, 1'b0, "st_exec");
    mcyc(1'b1, OP_ST, 1'b0, 1'b0, 3'd3, 8'b1100_0000, 1'b1, "st_mem_wait");
    mcyc(1'b0, OP_ST, 1'b0, 1'b0, 3'd3, SB_NONE, 1'b0, "st_mem_reset");
    m_instret = '0;
    run_instr(OP_AUI, 1'b0, 0, 0);

    // random instruction stream
    for (int n = 0; n < 120; n++) begin
      r  = int'($urandom_range(9, 0));
      op = (r == 0) ? 7'($urandom) : ops[$urandom_range(6, 0)];
      r  = int'($urandom_range(19, 0));
      fw = (r < 16) ? r % 3 : 13 + (r - 16);
      r  = int'($urandom_range(19, 0));
      mw = (r < 16) ? r % 4 : 13 + (r - 16);
      run_instr(op, rbit(), fw, mw);
      if (m_trapped) begin
        trap_idle(3);
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
